// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared types and constants for the cache memory arbiter
// Purpose: FSM state encoding, port index constants and default widths
//          used by cache_mem_arbiter and rr_arb2.
// Ports:   none (package).
package cache_pkg;

  localparam int ADDR_W_DEF = 64;
  localparam int DATA_W_DEF = 64;

  localparam logic PORT_IC = 1'b0;
  localparam logic PORT_DC = 1'b1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/cache_mem_arbiter_rr_arb2.sv
// rtl/cache_mem_arbiter_rr_arb2.sv - two-requester round-robin grant logic
// Purpose: purely combinational round-robin arbiter for two requesters.
// Ports:   req[1:0]   request bits (bit 0 = icache, bit 1 = dcache)
//          last_grant index of the port granted most recently
//          gnt[1:0]   one-hot grant (all zero when nothing requests)
module rr_arb2
  import cache_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt
);

  // On a tie the port that was not granted last time wins.
  always_comb begin
    gnt    = 2'b00;
    gnt[0] = req[0] & (~req[1] | (last_grant == PORT_DC));
    gnt[1] = req[1] & (~req[0] | (last_grant == PORT_IC));
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// rtl/cache_mem_arbiter.sv - shares one memory port between icache and dcache
// Purpose: round-robin arbitration of icache (port 0) and dcache (port 1)
//          refill/writeback requests onto a single memory port, one
//          transaction outstanding at a time.
// Ports:   clk, rst                     clock, synchronous active-high reset
//          pX_valid/we/addr/wdata/wstrb requester X request fields
//          pX_ready                     requester X accepted (IDLE only)
//          pX_resp_valid, pX_rdata      registered response to requester X
//          mem_valid/we/addr/wdata/wstrb memory request, held until mem_ready
//          mem_ready                    memory accepted the request
//          mem_resp_valid, mem_rdata    memory response
module cache_mem_arbiter
  import cache_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int STRB_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              p0_valid,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  input  logic [STRB_W-1:0] p0_wstrb,
  output logic              p0_ready,
  output logic              p0_resp_valid,
  output logic [DATA_W-1:0] p0_rdata,

  input  logic              p1_valid,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  input  logic [STRB_W-1:0] p1_wstrb,
  output logic              p1_ready,
  output logic              p1_resp_valid,
  output logic [DATA_W-1:0] p1_rdata,

  output logic              mem_valid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [STRB_W-1:0] mem_wstrb,
  input  logic              mem_ready,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t state, state_nx;
  logic   last_grant;
  logic   [1:0] gnt;

  // Request buffer: holds the accepted request for the whole transaction.
  logic              buf_we;
  logic [ADDR_W-1:0] buf_addr;
  logic [DATA_W-1:0] buf_wdata;
  logic [STRB_W-1:0] buf_wstrb;
  logic              buf_owner;

  rr_arb2 u_arb (
    .req        ({p1_valid, p0_valid}),
    .last_grant (last_grant),
    .gnt        (gnt)
  );

  always_comb begin
    state_nx = state;
    p0_ready = 1'b0;
    p1_ready = 1'b0;
    case (state)
      IDLE: begin
        p0_ready = gnt[0];
        p1_ready = gnt[1];
        if (gnt != 2'b00) state_nx = ISSUE;
      end
      ISSUE: begin
        if (mem_ready) state_nx = WAIT_RESP;
      end
      WAIT_RESP: begin
        if (mem_resp_valid) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Memory request fields come straight from the buffer, so they stay
  // stable for as long as ISSUE waits on mem_ready.
  assign mem_valid = (state == ISSUE);
  assign mem_we    = buf_we;
  assign mem_addr  = buf_addr;
  assign mem_wdata = buf_wdata;
  assign mem_wstrb = buf_wstrb;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      last_grant    <= PORT_DC;
      buf_we        <= 1'b0;
      buf_addr      <= '0;
      buf_wdata     <= '0;
      buf_wstrb     <= '0;
      buf_owner     <= PORT_IC;
      p0_resp_valid <= 1'b0;
      p1_resp_valid <= 1'b0;
      p0_rdata      <= '0;
      p1_rdata      <= '0;
    end else begin
      state         <= state_nx;
      p0_resp_valid <= 1'b0;
      p1_resp_valid <= 1'b0;

      if (state == IDLE && gnt != 2'b00) begin
        if (gnt[1]) begin
          buf_we    <= p1_we;
          buf_addr  <= p1_addr;
          buf_wdata <= p1_wdata;
          buf_wstrb <= p1_wstrb;
          buf_owner <= PORT_DC;
        end else begin
          buf_we    <= p0_we;
          buf_addr  <= p0_addr;
          buf_wdata <= p0_wdata;
          buf_wstrb <= p0_wstrb;
          buf_owner <= PORT_IC;
        end
      end

      // Writes return zero data; the non-owner's rdata keeps its old value.
      if (state == WAIT_RESP && mem_resp_valid) begin
        last_grant <= buf_owner;
        if (buf_owner == PORT_DC) begin
          p1_resp_valid <= 1'b1;
          p1_rdata      <= buf_we ? '0 : mem_rdata;
        end else begin
          p0_resp_valid <= 1'b1;
          p0_rdata      <= buf_we ? '0 : mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb/tb_cache_mem_arbiter.sv - directed self-checking bench for cache_mem_arbiter
module tb_cache_mem_arbiter;
  import cache_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_valid, p0_we, p0_ready, p0_resp_valid;
  logic [63:0] p0_addr, p0_wdata, p0_rdata;
  logic [7:0]  p0_wstrb;
  logic        p1_valid, p1_we, p1_ready, p1_resp_valid;
  logic [63:0] p1_addr, p1_wdata, p1_rdata;
  logic [7:0]  p1_wstrb;
  logic        mem_valid, mem_we, mem_ready, mem_resp_valid;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_wstrb;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  cache_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .p0_valid(p0_valid), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_wstrb(p0_wstrb), .p0_ready(p0_ready), .p0_resp_valid(p0_resp_valid),
    .p0_rdata(p0_rdata),
    .p1_valid(p1_valid), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_wstrb(p1_wstrb), .p1_ready(p1_ready), .p1_resp_valid(p1_resp_valid),
    .p1_rdata(p1_rdata),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    miscompares++;
    $error("FAIL timeout: bench did not finish, wait expired");
    $finish;
  end

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks are made 1 time unit after driving, well clear of the edge.
  task automatic settle();
    #1;
  endtask

  // Runs one transaction that the arbiter should grant in the current IDLE
  // cycle. Memory accepts at once and responds in the next cycle.
  task automatic run_txn(input logic port, input logic we, input logic [63:0] addr,
                         input logic [63:0] wdata, input logic [63:0] rdata,
                         input logic drop);
    settle();
    check("ready_win", port ? p1_ready : p0_ready, 1'b1);
    check("ready_lose", port ? p0_ready : p1_ready, 1'b0);
    tick();
    if (drop) begin
      if (port) p1_valid = 1'b0; else p0_valid = 1'b0;
    end
    mem_ready = 1'b1;
    settle();
    check("mem_valid", mem_valid, 1'b1);
    check("mem_addr", mem_addr, addr);
    check("mem_we", mem_we, we);
    if (we) begin
      check("mem_wdata", mem_wdata, wdata);
    end
    tick();
    mem_ready      = 1'b0;
    mem_resp_valid = 1'b1;
    mem_rdata      = rdata;
    tick();
    mem_resp_valid = 1'b0;
    settle();
    check("resp_owner", port ? p1_resp_valid : p0_resp_valid, 1'b1);
    check("resp_other", port ? p0_resp_valid : p1_resp_valid, 1'b0);
    check("rdata", port ? p1_rdata : p0_rdata, we ? 64'h0 : rdata);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    p0_valid = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0; p0_wstrb = '0;
    p1_valid = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0; p1_wstrb = '0;
    mem_ready = 0; mem_resp_valid = 0; mem_rdata = '0;
    do_reset();
    settle();

    // Reset state
    check("rst_state", dut.state, IDLE);
    check("rst_last_grant", dut.last_grant, 1'b1);
    check("rst_mem_valid", mem_valid, 1'b0);
    check("rst_mem_addr", mem_addr, 64'h0);
    check("rst_p0_resp", p0_resp_valid, 1'b0);
    check("rst_p1_resp", p1_resp_valid, 1'b0);
    check("rst_p0_rdata", p0_rdata, 64'h0);
    check("rst_p0_ready", p0_ready, 1'b0);

    // Single read on port 0; memory responds two cycles after accepting,
    // so the response shows up in cycle 4.
    tick();
    p0_valid = 1; p0_we = 0; p0_addr = 64'h8000_0010;
    settle();
    check("t1_c0_p0_ready", p0_ready, 1'b1);
    tick();                                    // cycle 1: ISSUE
    p0_valid = 0; mem_ready = 1;
    settle();
    check("t1_mem_valid", mem_valid, 1'b1);
    check("t1_mem_addr", mem_addr, 64'h8000_0010);
    check("t1_mem_we", mem_we, 1'b0);
    check("t1_p0_ready_issue", p0_ready, 1'b0);
    tick();                                    // cycle 2: WAIT_RESP
    mem_ready = 0;
    settle();
    check("t1_state_wait", dut.state, WAIT_RESP);
    check("t1_no_resp_c2", p0_resp_valid, 1'b0);
    tick();                                    // cycle 3
    mem_resp_valid = 1; mem_rdata = 64'hDEAD_BEEF_CAFE_F00D;
    tick();                                    // cycle 4
    mem_resp_valid = 0;
    settle();
    check("t1_c4_p0_resp", p0_resp_valid, 1'b1);
    check("t1_c4_rdata", p0_rdata, 64'hDEAD_BEEF_CAFE_F00D);
    check("t1_c4_p1_resp", p1_resp_valid, 1'b0);
    tick();
    settle();
    check("t1_resp_pulse", p0_resp_valid, 1'b0);
    check("t1_rdata_hold", p0_rdata, 64'hDEAD_BEEF_CAFE_F00D);

    // Simultaneous requests after reset: port 0 first, then the port 1 write
    do_reset();
    p0_valid = 1; p0_we = 0; p0_addr = 64'h100;
    p1_valid = 1; p1_we = 1; p1_addr = 64'h200; p1_wdata = 64'h11; p1_wstrb = 8'hFF;
    run_txn(1'b0, 1'b0, 64'h100, 64'h0, 64'h5555, 1'b1);
    run_txn(1'b1, 1'b1, 64'h200, 64'h11, 64'hABCD, 1'b1);

    // Sustained contention: both held valid, grants must alternate
    p0_valid = 1; p0_we = 0; p0_addr = 64'h300;
    p1_valid = 1; p1_we = 0; p1_addr = 64'h400;
    run_txn(1'b0, 1'b0, 64'h300, 64'h0, 64'hA0, 1'b0);
    run_txn(1'b1, 1'b0, 64'h400, 64'h0, 64'hA1, 1'b0);
    run_txn(1'b0, 1'b0, 64'h300, 64'h0, 64'hA2, 1'b0);
    run_txn(1'b1, 1'b0, 64'h400, 64'h0, 64'hA3, 1'b0);
    run_txn(1'b0, 1'b0, 64'h300, 64'h0, 64'hA4, 1'b0);
    run_txn(1'b1, 1'b0, 64'h400, 64'h0, 64'hA5, 1'b1);
    p0_valid = 0;

    // Memory backpressure with a late port 1 request
    tick();
    p0_valid = 1; p0_we = 0; p0_addr = 64'h500;
    settle();
    check("bp_p0_ready", p0_ready, 1'b1);
    tick();
    p0_valid = 0;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        p1_valid = 1; p1_we = 1; p1_addr = 64'h600; p1_wdata = 64'h77; p1_wstrb = 8'h0F;
      end
      settle();
      check("bp_mem_valid", mem_valid, 1'b1);
      check("bp_mem_addr", mem_addr, 64'h500);
      check("bp_p1_ready", p1_ready, 1'b0);
      tick();
    end
    mem_ready = 1;
    tick();
    mem_ready = 0; mem_resp_valid = 1; mem_rdata = 64'h5A5A;
    tick();
    mem_resp_valid = 0;
    settle();
    check("bp_p0_resp", p0_resp_valid, 1'b1);
    check("bp_p0_rdata", p0_rdata, 64'h5A5A);
    run_txn(1'b1, 1'b1, 64'h600, 64'h77, 64'hFFFF, 1'b1);

    // Spurious responses in IDLE and ISSUE
    tick();
    mem_resp_valid = 1; mem_rdata = 64'hBAD;
    tick();
    mem_resp_valid = 0;
    settle();
    check("sp_idle_p0", p0_resp_valid, 1'b0);
    check("sp_idle_p1", p1_resp_valid, 1'b0);
    check("sp_idle_state", dut.state, IDLE);
    p0_valid = 1; p0_we = 0; p0_addr = 64'h700;
    settle();
    check("sp_p0_ready", p0_ready, 1'b1);
    tick();
    p0_valid = 0; mem_resp_valid = 1;
    tick();
    mem_resp_valid = 0;
    settle();
    check("sp_issue_state", dut.state, ISSUE);
    check("sp_issue_p0", p0_resp_valid, 1'b0);
    check("sp_issue_p1", p1_resp_valid, 1'b0);
    mem_ready = 1;
    tick();
    mem_ready = 0; mem_resp_valid = 1; mem_rdata = 64'h700D;
    tick();
    mem_resp_valid = 0;
    settle();
    check("sp_real_resp", p0_resp_valid, 1'b1);
    check("sp_real_rdata", p0_rdata, 64'h700D);

    // Reset while waiting for a response
    tick();
    p0_valid = 1; p0_we = 0; p0_addr = 64'h800;
    tick();
    p0_valid = 0; mem_ready = 1;
    tick();
    mem_ready = 0;
    settle();
    check("mr_state_wait", dut.state, WAIT_RESP);
    rst = 1;
    tick();
    rst = 0;
    settle();
    check("mr_state", dut.state, IDLE);
    check("mr_last_grant", dut.last_grant, 1'b1);
    check("mr_mem_valid", mem_valid, 1'b0);
    check("mr_mem_addr", mem_addr, 64'h0);
    check("mr_p0_resp", p0_resp_valid, 1'b0);
    check("mr_p0_rdata", p0_rdata, 64'h0);
    check("mr_p1_rdata", p1_rdata, 64'h0);
    p1_valid = 1; p1_we = 0; p1_addr = 64'h900;
    run_txn(1'b1, 1'b0, 64'h900, 64'h0, 64'h9999, 1'b1);

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
